// File: rtl/l2_cacheline_adaptor_pkg.sv
// Shared types for the L2 pmem-side cacheline adaptor.
// The L2 mux select enums live in their own packages and are not needed here.
package l2_adaptor_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// Converts whole-line L2 read/write requests into BURSTS-beat memory bursts; best-case read is
// accept + BURSTS beats + one DONE cycle, and memory stalls (resp_i low) simply hold the burst.
module l2_cacheline_adaptor
  import l2_adaptor_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BURSTS   = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);

  adaptor_state_t        state;
  adaptor_state_t        state_next;
  logic [CNT_W-1:0]      count;
  logic [LINE_WIDTH-1:0] buffer;
  logic [LINE_WIDTH-1:0] line_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_beat;

  assign last_beat = resp_i && (count == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_i) begin
          state_next = WRITE;
        end else if (read_i) begin
          state_next = READ;
        end
      end
      READ, WRITE: begin
        if (last_beat) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The counter wraps to zero on the final beat; harmless since the state leaves READ/WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      buffer <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            addr_q <= {address_i[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
            buffer <= line_i;
            count  <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            buffer[count*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) begin
            count <= count + 1'b1;
          end
        end
        DONE:    line_q <= buffer;
        default: ;
      endcase
    end
  end

  assign read_o    = (state == READ);
  assign write_o   = (state == WRITE);
  assign resp_o    = (state == DONE);
  assign address_o = addr_q;
  assign burst_o   = (state == WRITE) ? buffer[count*BURST_WIDTH +: BURST_WIDTH] : '0;
  // line_o shows the buffer during DONE and keeps that line afterwards.
  assign line_o    = (state == DONE) ? buffer : line_q;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
// Directed and randomized transactions against a line-granular memory model.
module tb_l2_cacheline_adaptor;

  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;
  localparam int LINE_BYTES = LW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic [AW-1:0] address_i;
  logic          read_i;
  logic          write_i;
  logic          resp_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic [AW-1:0] address_o;
  logic          read_o;
  logic          write_o;
  logic          resp_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [LW-1:0] mem [logic [AW-1:0]];
  int resp_times[$];

  l2_cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // gmode: 0 = no gaps, 1 = random gaps, 2 = strobe pattern 1,0,1,0,1,1
  task automatic run_txn(input string tag, input logic is_wr, input logic both,
                         input logic [AW-1:0] addr, input logic [LW-1:0] wl,
                         input int gmode, input logic chk_lat);
    logic [AW-1:0] al;
    logic [LW-1:0] exp_line;
    logic [LW-1:0] got_line;
    logic [5:0]    pat;
    int beats, pidx, cyc_n;
    bit done, give, bad_addr, bad_dir, bad_hold;
    al = (addr / LINE_BYTES) * LINE_BYTES;
    if (!is_wr && !mem.exists(al)) mem[al] = rand_line();
    exp_line = is_wr ? wl : mem[al];
    got_line = '0;
    pat = 6'b110101;
    beats = 0; pidx = 0; cyc_n = 0;
    done = 0; bad_addr = 0; bad_dir = 0; bad_hold = 0;
    address_i = addr;
    line_i    = wl;
    write_i   = is_wr;
    read_i    = !is_wr || both;
    while (!done && cyc_n < 80) begin
      @(negedge clk);
      cyc_n++;
      resp_i  = 1'b0;
      burst_i = '0;
      address_i = $urandom;
      line_i    = rand_line();
      if (resp_o) begin
        done = 1;
        resp_times.push_back(cyc);
        chk({tag, "_beats"}, beats, NB);
        chk({tag, "_line_o"}, line_o, exp_line);
        if (chk_lat) chk({tag, "_latency"}, cyc_n + 1, 1 + NB + 1);
      end
      if ((read_o || write_o) && address_o !== al) bad_addr = 1;
      if (is_wr ? read_o : write_o) bad_dir = 1;
      if ((read_o || write_o) && beats < NB) begin
        if (write_o && burst_o !== wl[beats*BW +: BW]) bad_hold = 1;
        case (gmode)
          0:       give = 1;
          1:       give = ($urandom_range(0, 2) != 0);
          default: give = pat[pidx % 6];
        endcase
        pidx++;
        if (give) begin
          resp_i = 1'b1;
          if (read_o) burst_i = exp_line[beats*BW +: BW];
          else        got_line[beats*BW +: BW] = burst_o;
          beats++;
        end
      end
    end
    chk({tag, "_completed"}, done, 1'b1);
    chk({tag, "_address_o"}, bad_addr, 1'b0);
    chk({tag, "_wrong_direction"}, bad_dir, 1'b0);
    if (is_wr) begin
      chk({tag, "_burst_held"}, bad_hold, 1'b0);
      chk({tag, "_beats_written"}, got_line, wl);
      mem[al] = got_line;
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    resp_i  = 1'b0;
    @(negedge clk);
    chk({tag, "_single_resp"}, {resp_o, read_o, write_o}, 3'b000);
  endtask

  initial begin
    logic [LW-1:0] d;
    logic [AW-1:0] a;
    rst = 1'b1;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;

    #2;
    chk("reset_ctrl", {resp_o, read_o, write_o}, 3'b000);
    chk("reset_address_o", address_o, '0);
    chk("reset_burst_o", burst_o, '0);
    chk("reset_line_o", line_o, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Read, no gaps, known data
    mem[32'h0000_1220] = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    run_txn("read_nogap", 1'b0, 1'b0, 32'h0000_1234, '0, 0, 1'b1);

    // Write with gaps
    d = {{8{8'hD3}}, {8{8'hD2}}, {8{8'hD1}}, {8{8'hD0}}};
    run_txn("write_gaps", 1'b1, 1'b0, 32'h0000_0800, d, 2, 1'b0);
    run_txn("readback_write", 1'b0, 1'b0, 32'h0000_0810, '0, 0, 1'b0);

    // Simultaneous read and write: write wins
    run_txn("both_high", 1'b1, 1'b1, 32'h0000_0a00, rand_line(), 0, 1'b1);

    // Reset in the middle of a read
    address_i = 32'h0000_0040;
    read_i = 1'b1;
    @(negedge clk);
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    resp_i = 1'b0;
    chk("midread_read_o_before", {read_o, resp_o}, 2'b10);
    #1 rst = 1'b1;
    #1;
    chk("midread_async_drop", {read_o, resp_o, write_o}, 3'b000);
    chk("midread_address_o", address_o, '0);
    read_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem[32'h0000_0040] = rand_line();
    run_txn("read_after_reset", 1'b0, 1'b0, 32'h0000_0040, '0, 0, 1'b1);

    // Spurious strobes while idle
    for (int i = 0; i < 3; i++) begin
      resp_i = 1'b1;
      burst_i = {$urandom, $urandom};
      @(negedge clk);
      chk("spurious_idle", {resp_o, read_o, write_o}, 3'b000);
    end
    resp_i = 1'b0;
    run_txn("read_after_spurious", 1'b0, 1'b0, 32'h0000_0c1f, '0, 0, 1'b1);

    // Back-to-back write then read of the same line
    resp_times.delete();
    d = rand_line();
    run_txn("b2b_write", 1'b1, 1'b0, 32'h0000_0100, d, 0, 1'b1);
    run_txn("b2b_read", 1'b0, 1'b0, 32'h0000_0100, '0, 0, 1'b1);
    chk("b2b_pulse_count", resp_times.size(), 2);
    if (resp_times.size() == 2)
      chk("b2b_separation_ge6", (resp_times[1] - resp_times[0]) >= 6, 1'b1);

    // Randomized mix over a small address window
    for (int i = 0; i < 10; i++) begin
      a = 32'h0000_2000 + $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1)
        run_txn("rand_write", 1'b1, $urandom_range(0, 1) == 1, a, rand_line(), 1, 1'b0);
      else
        run_txn("rand_read", 1'b0, 1'b0, a, '0, 1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
